// File: rtl/uart_cmd_handler.sv
// rtl/uart_cmd_handler.sv - two-byte UART command front end with two-byte response transmit
// Optional inter-byte timeout in WAIT_ADDR is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_handler #(
  parameter int unsigned BYTE_TIMEOUT = 50_000_000,
  parameter int unsigned RSP_TIMEOUT  = 5_000_000,
  parameter int unsigned MAX_ADDR     = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_addr,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_code,
  input  logic [7:0] rsp_data,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, WAIT_ADDR, ISSUE, WAIT_RSP, SEND0, WAIT0, SEND1, WAIT1
  } state_t;

  localparam logic [31:0] RSP_LAST  = 32'(RSP_TIMEOUT - 1);
  localparam logic [31:0] TIMER_MAX = '1;

  state_t      state, state_nxt;
  logic [7:0]  byte0, byte1;
  logic [31:0] rsp_timer;
  logic        addr_ok;
  logic        rsp_expired;
  logic        byte_expired;

  assign addr_ok     = (32'(rx_byte) <= MAX_ADDR);
  assign rsp_expired = (rsp_timer == RSP_LAST);

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] BYTE_LAST = 32'(BYTE_TIMEOUT - 1);
  logic [31:0] byte_timer;

  // Restarts from zero on every entry to WAIT_ADDR; saturates instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      byte_timer <= '0;
    else if (state != WAIT_ADDR)
      byte_timer <= '0;
    else if (byte_timer != TIMER_MAX)
      byte_timer <= byte_timer + 32'd1;
  end

  assign byte_expired = (state == WAIT_ADDR) && (byte_timer == BYTE_LAST) && !rx_done;
`else
  assign byte_expired = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    tx_dv     = 1'b0;
    tx_byte   = 8'h00;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rx_done) state_nxt = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        busy = 1'b0;
        if (rx_done)
          state_nxt = addr_ok ? ISSUE : SEND0;
        else if (byte_expired)
          state_nxt = IDLE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_valid || rsp_expired) state_nxt = SEND0;
      end
      SEND0: begin
        tx_byte = byte0;
        if (!tx_active) begin
          tx_dv     = 1'b1;
          state_nxt = WAIT0;
        end
      end
      WAIT0: begin
        tx_byte = byte0;
        if (tx_done) state_nxt = SEND1;
      end
      SEND1: begin
        tx_byte = byte1;
        if (!tx_active) begin
          tx_dv     = 1'b1;
          state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        tx_byte = byte1;
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response bytes are loaded once per command: error code, consumer reply or timeout code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_code  <= 8'h00;
      cmd_addr  <= 8'h00;
      byte0     <= 8'h00;
      byte1     <= 8'h00;
      rsp_timer <= '0;
      overrun   <= 1'b0;
    end else begin
      if (rx_done && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rx_done) cmd_code <= rx_byte;
        end
        WAIT_ADDR: begin
          if (rx_done) begin
            cmd_addr <= rx_byte;
            if (!addr_ok) begin
              byte0 <= 8'hFE;
              byte1 <= 8'h00;
            end
          end else if (byte_expired) begin
            cmd_code <= 8'h00;
          end
        end
        ISSUE: begin
          rsp_timer <= '0;
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            byte0 <= rsp_code;
            byte1 <= rsp_data;
          end else if (rsp_expired) begin
            byte0 <= 8'hFD;
            byte1 <= 8'h00;
          end else if (rsp_timer != TIMER_MAX) begin
            rsp_timer <= rsp_timer + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_handler.sv
// tb/tb_uart_cmd_handler.sv - self-checking bench for uart_cmd_handler
`timescale 1ns/1ps
module tb_uart_cmd_handler;

  localparam int BT = 100;
  localparam int RT = 50;
  localparam int MA = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_addr;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_code = 8'h00;
  logic [7:0] rsp_data = 8'h00;
  logic       busy;
  logic       overrun;

  uart_cmd_handler #(.BYTE_TIMEOUT(BT), .RSP_TIMEOUT(RT), .MAX_ADDR(MA)) dut (
    .clock(clock), .reset(reset), .rx_done(rx_done), .rx_byte(rx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_data(rsp_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errs = 0;
  int n_checks = 0;

  // Environment state: consumer response schedule and a UART transmitter model.
  int         rsp_dly = -1;
  int         rsp_at = -1;
  logic [7:0] cfg_rc = 8'h00;
  logic [7:0] cfg_rd = 8'h00;
  int         tx_cnt = 0;
  bit         done_pend = 1'b0;
  int         n_done = 0;
  int         tx_hold_until = 0;
  int         txact_bad = 0;

  int         cv_cyc[$];
  logic [7:0] cv_code[$];
  logic [7:0] cv_addr[$];
  int         tx_cyc[$];
  logic [7:0] tx_b[$];
  int         tx_ndone[$];

  always @(negedge clock) begin
    if (tx_cnt > 0) begin
      tx_active = 1'b1;
      tx_done   = 1'b0;
      tx_cnt--;
      if (tx_cnt == 0) done_pend = 1'b1;
    end else if (done_pend) begin
      tx_active = 1'b0;
      tx_done   = 1'b1;
      done_pend = 1'b0;
      n_done++;
    end else begin
      tx_done   = 1'b0;
      tx_active = (cyc < tx_hold_until);
    end
    rsp_valid = (rsp_at >= 0) && (cyc == rsp_at);
    rsp_code  = cfg_rc;
    rsp_data  = cfg_rd;
    #1;
    if (cmd_valid === 1'b1) begin
      cv_cyc.push_back(cyc);
      cv_code.push_back(cmd_code);
      cv_addr.push_back(cmd_addr);
      if (rsp_dly >= 0) rsp_at = cyc + rsp_dly;
    end
    if (tx_dv === 1'b1) begin
      tx_cyc.push_back(cyc);
      tx_b.push_back(tx_byte);
      tx_ndone.push_back(n_done);
      if (tx_active) txact_bad++;
      tx_cnt = 3;
    end
  end

  typedef struct {
    logic [7:0] c;
    logic [7:0] a;
    int         d;
    logic [7:0] rc;
    logic [7:0] rd;
    int         hold;
    bit         ei;
    logic [7:0] e0;
    logic [7:0] e1;
    int         el;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: legal address issues a command; the consumer reply is used if it lands
  // within the RT-cycle response window, else FD/00; an illegal address answers FE/00.
  // Latency is counted from the cycle carrying the address byte to the first tx_dv.
  function automatic void model(input logic [7:0] a, input int d, input logic [7:0] rc,
                                input logic [7:0] rd, input int hold, output bit issue,
                                output logic [7:0] e0, output logic [7:0] e1, output int lat);
    issue = (int'(a) <= MA);
    if (!issue) begin
      e0 = 8'hFE; e1 = 8'h00; lat = 1;
    end else if (d >= 1 && d <= RT) begin
      e0 = rc; e1 = rd; lat = d + 2;
    end else begin
      e0 = 8'hFD; e1 = 8'h00; lat = RT + 2;
    end
    if (hold > lat) lat = hold;
  endfunction

  task automatic start_txn(input int d, input logic [7:0] rc, input logic [7:0] rd);
    @(posedge clock);
    cv_cyc.delete(); cv_code.delete(); cv_addr.delete();
    tx_cyc.delete(); tx_b.delete(); tx_ndone.delete();
    n_done = 0; rsp_at = -1; rsp_dly = d; cfg_rc = rc; cfg_rd = rd;
    tx_hold_until = 0; txact_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int at);
    @(negedge clock);
    rx_done = 1'b1;
    rx_byte = b;
    at = cyc;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int b = 0;
    while (!(tx_cyc.size() >= 2 && n_done >= 2) && b < 500) begin
      @(negedge clock);
      b++;
    end
    check($sformatf("%s txn_complete", tag), 32'(b < 500), 32'd1);
    repeat (5) @(negedge clock);
    #2;
  endtask

  task automatic verify(input string tag, input bit issue, input logic [7:0] c, input logic [7:0] a,
                        input logic [7:0] e0, input logic [7:0] e1, input int at, input int lat);
    check($sformatf("%s cmd_count", tag), cv_cyc.size(), issue ? 32'd1 : 32'd0);
    if (issue && cv_cyc.size() > 0) begin
      check($sformatf("%s cmd_code", tag), cv_code[0], c);
      check($sformatf("%s cmd_addr", tag), cv_addr[0], a);
      check($sformatf("%s cmd_cycle", tag), cv_cyc[0], at + 1);
    end
    check($sformatf("%s tx_count", tag), tx_cyc.size(), 32'd2);
    if (tx_cyc.size() >= 2) begin
      check($sformatf("%s tx_byte0", tag), tx_b[0], e0);
      check($sformatf("%s tx_byte1", tag), tx_b[1], e1);
      check($sformatf("%s tx_latency", tag), tx_cyc[0] - at, lat);
      check($sformatf("%s tx_order", tag), tx_ndone[1], tx_ndone[0] + 1);
      check($sformatf("%s tx_while_active", tag), txact_bad, 32'd0);
    end
    check($sformatf("%s busy_end", tag), busy, 1'b0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int a0, at;
    start_txn(v.d, v.rc, v.rd);
    send_byte(v.c, a0);
    tx_hold_until = (v.hold > 0) ? a0 + 2 + v.hold : 0;
    send_byte(v.a, at);
    wait_done(tag);
    verify(tag, v.ei, v.c, v.a, v.e0, v.e1, at, v.el);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s tx_dv", tag), tx_dv, 1'b0);
    check($sformatf("%s cmd_valid", tag), cmd_valid, 1'b0);
    check($sformatf("%s busy", tag), busy, 1'b0);
    check($sformatf("%s overrun", tag), overrun, 1'b0);
    check($sformatf("%s tx_byte", tag), tx_byte, 8'h00);
    check($sformatf("%s cmd_code", tag), cmd_code, 8'h00);
    check($sformatf("%s cmd_addr", tag), cmd_addr, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    vec_t v;
    int   a0, at, ntx;
    int   b;

    vt[0] = '{8'h01, 8'h05,  2, 8'h10, 8'h2A,  0, 1'b1, 8'h10, 8'h2A,  4};
    vt[1] = '{8'h03, 8'h40,  2, 8'h11, 8'h22,  0, 1'b0, 8'hFE, 8'h00,  1};
    vt[2] = '{8'h02, 8'h01, 60, 8'h33, 8'h44,  0, 1'b1, 8'hFD, 8'h00, 52};
    vt[3] = '{8'h04, 8'h1F,  1, 8'h77, 8'h88,  0, 1'b1, 8'h77, 8'h88,  3};
    vt[4] = '{8'h05, 8'h20,  1, 8'h77, 8'h88,  0, 1'b0, 8'hFE, 8'h00,  1};
    vt[5] = '{8'h06, 8'h00, 50, 8'hAB, 8'hCD,  0, 1'b1, 8'hAB, 8'hCD, 52};
    vt[6] = '{8'h07, 8'h02, 51, 8'hAB, 8'hCD,  0, 1'b1, 8'hFD, 8'h00, 52};
    vt[7] = '{8'h08, 8'hFF,  1, 8'h01, 8'h02,  0, 1'b0, 8'hFE, 8'h00,  1};
    vt[8] = '{8'h09, 8'h03,  1, 8'h5A, 8'hA5, 10, 1'b1, 8'h5A, 8'hA5, 10};
    vt[9] = '{8'h0A, 8'hFE,  1, 8'h01, 8'h02,  6, 1'b0, 8'hFE, 8'h00,  6};

    reset = 1'b0;
    #1 reset = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    for (int i = 0; i < 30; i++) begin
      v.c    = 8'($urandom);
      v.a    = 8'($urandom_range(0, 63));
      v.d    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 60));
      v.rc   = 8'($urandom);
      v.rd   = 8'($urandom);
      v.hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
      model(v.a, v.d, v.rc, v.rd, v.hold, v.ei, v.e0, v.e1, v.el);
      run_vec($sformatf("rand%0d", i), v);
    end
    check("overrun_clean", overrun, 1'b0);

    // Extra byte during WAIT_RSP is dropped and flagged.
    start_txn(10, 8'h66, 8'h99);
    send_byte(8'h0B, a0);
    send_byte(8'h04, at);
    send_byte(8'h55, b);
    wait_done("ovr");
    verify("ovr", 1'b1, 8'h0B, 8'h04, 8'h66, 8'h99, at, 12);
    check("ovr overrun", overrun, 1'b1);
    check("ovr cmd_addr_held", cmd_addr, 8'h04);

    // Reset while the first response byte is in flight.
    start_txn(2, 8'h12, 8'h34);
    send_byte(8'h0C, a0);
    send_byte(8'h06, at);
    b = 0;
    while (tx_cyc.size() < 1 && b < 200) begin
      @(negedge clock);
      b++;
    end
    check("rst_mid reached_wait0", 32'(b < 200), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    ntx = tx_cyc.size();
    repeat (60) @(negedge clock);
    #2;
    check("rst_mid no_tx_after", tx_cyc.size(), ntx);
    check("rst_mid busy_after", busy, 1'b0);

    // Long gap after the command byte.
    start_txn(1, 8'h21, 8'h43);
    send_byte(8'h01, a0);
    repeat (120) @(negedge clock);
    send_byte(8'h07, at);
    send_byte(8'h02, b);
    wait_done("gap");
    check("gap cmd_count", cv_cyc.size(), 32'd1);
    if (cv_cyc.size() > 0) begin
`ifdef UART_CMD_TIMEOUT_EN
      check("gap cmd_code", cv_code[0], 8'h07);
      check("gap cmd_addr", cv_addr[0], 8'h02);
      check("gap overrun", overrun, 1'b0);
`else
      check("gap cmd_code", cv_code[0], 8'h01);
      check("gap cmd_addr", cv_addr[0], 8'h07);
      check("gap overrun", overrun, 1'b1);
`endif
    end
    if (tx_cyc.size() >= 2) begin
      check("gap tx_byte0", tx_b[0], 8'h21);
      check("gap tx_byte1", tx_b[1], 8'h43);
    end

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end

endmodule
